// File: rtl/bpt_bht_pkg.sv
// Shared constants for the branch predictor: funct3 codes, counter encodings, saturating update.
package bpt_bht_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] B_EQ  = 3'b000;
  localparam logic [2:0] B_NE  = 3'b001;
  localparam logic [2:0] B_LT  = 3'b100;
  localparam logic [2:0] B_GE  = 3'b101;
  localparam logic [2:0] B_LTU = 3'b110;
  localparam logic [2:0] B_GEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RST = CTR_WNT;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bpt_resolve.sv
// EX-stage branch resolver: actual outcome from funct3 + ALU flags, mispredict and redirect PC.
module bpt_resolve #(
  parameter int XLEN = 32
) (
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_take,
  input  logic            alu_zero,
  input  logic            alu_sign,
  input  logic            alu_carry,
  output logic            actual,
  output logic            predict_fail,
  output logic [XLEN-1:0] fail_addr
);
  import bpt_bht_pkg::*;

  always_comb begin
    actual = 1'b0;
    case (ex_funct)
      B_EQ:    actual = alu_zero;
      B_NE:    actual = ~alu_zero;
      B_LT:    actual = alu_sign;
      B_GE:    actual = ~alu_sign;
      B_LTU:   actual = alu_carry;
      B_GEU:   actual = ~alu_carry;
      default: actual = 1'b0;
    endcase
  end

  assign predict_fail = ex_branch & (ex_take ^ actual);
  assign fail_addr    = actual ? ex_pc + ex_imm : ex_pc + XLEN'(4);

endmodule

// File: rtl/bpt_bht.sv
// Bimodal 2-bit branch history table with same-cycle write bypass and EX resolver.
// Optional global-history (gshare) indexing when BPT_GSHARE_EN is defined.
module bpt_bht #(
  parameter  int XLEN        = 32,
  parameter  int BHT_ENTRIES = 64,
  parameter  int IDX_LSB     = 2,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_branch,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_imm,
  output logic             if_take,
  output logic [XLEN-1:0]  if_target,
  output logic [IDX_W-1:0] if_idx,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_take,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry,
  output logic             predict_fail,
  output logic             bxx_flush,
  output logic [XLEN-1:0]  fail_addr
);
  import bpt_bht_pkg::*;

  ctr_t [BHT_ENTRIES-1:0] ctr_q;
  ctr_t                   ex_upd;
  ctr_t                   rd_ctr;
  logic                   actual;

  bpt_resolve #(.XLEN(XLEN)) u_resolve (
    .ex_branch    (ex_branch),
    .ex_funct     (ex_funct),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_take      (ex_take),
    .alu_zero     (alu_zero),
    .alu_sign     (alu_sign),
    .alu_carry    (alu_carry),
    .actual       (actual),
    .predict_fail (predict_fail),
    .fail_addr    (fail_addr)
  );

  assign bxx_flush = predict_fail;
  assign ex_upd    = ctr_next(ctr_q[ex_idx], actual);

  for (genvar e = 0; e < BHT_ENTRIES; e++) begin : g_ctr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  ctr_q[e] <= CTR_RST;
      else if (ex_branch && ex_idx == IDX_W'(e))   ctr_q[e] <= ex_upd;
    end
  end

`ifdef BPT_GSHARE_EN
  // History holds resolved outcomes only, so a flush never needs to repair it.
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ghr <= '0;
    else if (ex_branch) ghr <= (ghr << 1) | IDX_W'(actual);
  end

  assign if_idx = if_pc[IDX_LSB +: IDX_W] ^ ghr;
`else
  assign if_idx = if_pc[IDX_LSB +: IDX_W];
`endif

  // A read colliding with this cycle's training write sees the updated counter.
  assign rd_ctr    = (ex_branch && if_idx == ex_idx) ? ex_upd : ctr_q[if_idx];
  assign if_take   = if_branch & rd_ctr[1];
  assign if_target = if_pc + if_imm;

endmodule

// File: tb/tb_bpt_bht.sv
// Self-checking bench for bpt_bht: directed tables, hand sequences and a randomized model run.
module tb_bpt_bht;
  import bpt_bht_pkg::*;

  localparam int NE = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_branch;
  logic [31:0] if_pc, if_imm;
  logic        if_take;
  logic [31:0] if_target;
  logic [5:0]  if_idx;
  logic        ex_branch;
  logic [2:0]  ex_funct;
  logic [31:0] ex_pc, ex_imm;
  logic        ex_take;
  logic [5:0]  ex_idx;
  logic        alu_zero, alu_sign, alu_carry;
  logic        predict_fail, bxx_flush;
  logic [31:0] fail_addr;

  always #5 clk = ~clk;

  bpt_bht dut (
    .clk(clk), .rst_n(rst_n),
    .if_branch(if_branch), .if_pc(if_pc), .if_imm(if_imm),
    .if_take(if_take), .if_target(if_target), .if_idx(if_idx),
    .ex_branch(ex_branch), .ex_funct(ex_funct), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_take(ex_take), .ex_idx(ex_idx),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
    .predict_fail(predict_fail), .bxx_flush(bxx_flush), .fail_addr(fail_addr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model: counters as integers 0..3, history as an integer.
  int cnt [NE];
  int ghr;
  bit m_a;

  function automatic bit m_act(input logic [2:0] f, input logic z, input logic s, input logic c);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s;
      3'd5: return !s;
      3'd6: return c;
      3'd7: return !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    int i;
    i = int'(pc / 4) % NE;
`ifdef BPT_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) cnt[i] = 1;
      ghr = 0;
    end else if (ex_branch) begin
      m_a = m_act(ex_funct, alu_zero, alu_sign, alu_carry);
      cnt[ex_idx] = m_sat(cnt[ex_idx], m_a);
      ghr = ((ghr * 2) + int'(m_a)) % NE;
    end
  end

  task automatic check_model();
    int i, c;
    bit a, pf;
    i  = m_idx(if_pc);
    a  = m_act(ex_funct, alu_zero, alu_sign, alu_carry);
    c  = cnt[i];
    if (ex_branch && i == int'(ex_idx)) c = m_sat(c, a);
    pf = ex_branch && (ex_take != a);
    chk("m_if_idx", 32'(if_idx), 32'(i));
    chk("m_if_take", 32'(if_take), 32'(if_branch && c >= 2));
    chk("m_if_target", if_target, if_pc + if_imm);
    chk("m_predict_fail", 32'(predict_fail), 32'(pf));
    chk("m_bxx_flush", 32'(bxx_flush), 32'(pf));
    if (pf) chk("m_fail_addr", fail_addr, a ? ex_pc + ex_imm : ex_pc + 32'd4);
  endtask

  task automatic idle();
    if_branch = 0; if_pc = 0; if_imm = 0;
    ex_branch = 0; ex_funct = 0; ex_pc = 0; ex_imm = 0; ex_take = 0; ex_idx = 0;
    alu_zero = 0; alu_sign = 0; alu_carry = 0;
  endtask

  task automatic resolve(input bit br, input logic [2:0] f, input logic z, input logic [5:0] idx, input bit tk);
    ex_branch = br; ex_funct = f; alu_zero = z; alu_sign = 0; alu_carry = 0;
    ex_idx = idx; ex_take = tk; ex_pc = 32'h14; ex_imm = 32'h40;
  endtask

  typedef struct {
    logic        exb;
    logic [2:0]  f;
    logic        z, s, c, t;
    logic [31:0] pc, imm;
    logic        pf;
    logic [31:0] addr;
  } rvec_t;

  rvec_t tv [11];

  initial begin
    tv[0]  = '{1'b1, B_NE,   1'b0, 1'b0, 1'b0, 1'b0, 32'h200,      32'hFFFFFFF0, 1'b1, 32'h1F0};
    tv[1]  = '{1'b1, B_LTU,  1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h100,      1'b1, 32'h0};
    tv[2]  = '{1'b1, B_EQ,   1'b1, 1'b0, 1'b0, 1'b1, 32'h40,       32'h8,        1'b0, 32'h48};
    tv[3]  = '{1'b1, B_EQ,   1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       32'h8,        1'b1, 32'h44};
    tv[4]  = '{1'b1, B_LT,   1'b0, 1'b1, 1'b0, 1'b0, 32'h1000,     32'h80,       1'b1, 32'h1080};
    tv[5]  = '{1'b1, B_GE,   1'b0, 1'b1, 1'b0, 1'b0, 32'h1000,     32'h80,       1'b0, 32'h1004};
    tv[6]  = '{1'b1, B_GE,   1'b0, 1'b0, 1'b0, 1'b0, 32'h1000,     32'h80,       1'b1, 32'h1080};
    tv[7]  = '{1'b1, B_GEU,  1'b0, 1'b0, 1'b1, 1'b1, 32'h300,      32'h10,       1'b1, 32'h304};
    tv[8]  = '{1'b1, B_LTU,  1'b0, 1'b0, 1'b1, 1'b1, 32'h300,      32'h10,       1'b0, 32'h310};
    tv[9]  = '{1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 32'h500,      32'h40,       1'b1, 32'h504};
    tv[10] = '{1'b0, B_NE,   1'b0, 1'b0, 1'b0, 1'b0, 32'h600,      32'h40,       1'b0, 32'h640};

    idle();
    rst_n = 0;
    if_branch = 1; if_pc = 32'h1234;
    #12;
    chk("rst_pf", 32'(predict_fail), 32'd0);
    chk("rst_flush", 32'(bxx_flush), 32'd0);
    chk("rst_take", 32'(if_take), 32'd0);
    @(negedge clk); rst_n = 1;

    // Fresh table: weakly not-taken everywhere, target arithmetic.
    if_branch = 1; if_pc = 32'h100; if_imm = 32'h20;
    #2;
    chk("init_take", 32'(if_take), 32'd0);
    chk("init_target", if_target, 32'h120);
    chk("init_idx", 32'(if_idx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if_pc = $urandom(); #1;
      chk("init_take_rand", 32'(if_take), 32'd0);
    end

`ifndef BPT_GSHARE_EN
    // Counter walk at index 5: 01 -> 10 -> 11 (sat) -> 10 -> 01.
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd5, 0); #2;
    chk("tr1_pf", 32'(predict_fail), 32'd1);
    chk("tr1_addr", fail_addr, 32'h54);
    chk("tr1_take_nobr", 32'(if_take), 32'd0);
    @(negedge clk); idle(); if_branch = 1; if_pc = 32'h14; #2;
    chk("tr2_take_wt", 32'(if_take), 32'd1);
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd5, 1); if_branch = 1; if_pc = 32'h100; #2;
    chk("tr3_take_other", 32'(if_take), 32'd0);
    @(negedge clk); idle(); if_branch = 1; if_pc = 32'h14; #2;
    chk("tr4_take_st", 32'(if_take), 32'd1);
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd5, 1); #2;
    chk("tr5_pf", 32'(predict_fail), 32'd0);
    @(negedge clk); idle(); resolve(1, B_EQ, 0, 6'd5, 1); if_branch = 1; if_pc = 32'h14; #2;
    chk("tr6_sat_bypass", 32'(if_take), 32'd1);
    @(negedge clk); idle(); resolve(1, B_EQ, 0, 6'd5, 1); if_branch = 1; if_pc = 32'h14; #2;
    chk("tr7_dec_bypass", 32'(if_take), 32'd0);
    @(negedge clk); idle(); if_branch = 1; if_pc = 32'h14; #2;
    chk("tr8_take_wnt", 32'(if_take), 32'd0);

    // Same-cycle bypass on an untouched entry.
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd3, 1); if_branch = 1; if_pc = 32'h0C; #2;
    chk("byp_take", 32'(if_take), 32'd1);
    chk("byp_pf", 32'(predict_fail), 32'd0);
`endif

    // Resolver vector table.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); idle();
      ex_branch = tv[i].exb; ex_funct = tv[i].f; alu_zero = tv[i].z; alu_sign = tv[i].s;
      alu_carry = tv[i].c; ex_take = tv[i].t; ex_pc = tv[i].pc; ex_imm = tv[i].imm;
      ex_idx = 6'(16 + i);
      #2;
      chk($sformatf("tv%0d_pf", i), 32'(predict_fail), 32'(tv[i].pf));
      chk($sformatf("tv%0d_flush", i), 32'(bxx_flush), 32'(tv[i].pf));
      if (tv[i].pf) chk($sformatf("tv%0d_addr", i), fail_addr, tv[i].addr);
      check_model();
    end

    // Randomized run against the model, indices folded onto a few entries for collisions.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if_branch = 1'($urandom_range(0, 1));
      if_pc     = ($urandom() & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      if_imm    = $urandom();
      ex_branch = ($urandom_range(0, 3) != 0);
      ex_funct  = 3'($urandom_range(0, 7));
      ex_pc     = $urandom();
      ex_imm    = $urandom();
      ex_take   = 1'($urandom_range(0, 1));
      ex_idx    = 6'($urandom_range(0, 7));
      alu_zero  = 1'($urandom_range(0, 1));
      alu_sign  = 1'($urandom_range(0, 1));
      alu_carry = 1'($urandom_range(0, 1));
      #2;
      check_model();
    end

    // Reset mid-run, held across an edge with a training request pending.
    @(negedge clk); idle(); #2;
    rst_n = 0;
    ex_branch = 1; ex_funct = B_EQ; alu_zero = 1; ex_idx = 6'd3; ex_take = 1;
    #1;
    chk("mid_rst_take", 32'(if_take), 32'd0);
    @(negedge clk); idle(); rst_n = 1;
    for (int k = 0; k < NE; k++) begin
      if_branch = 1; if_pc = 32'(k) << 2; #1;
      chk("post_rst_idx", 32'(if_idx), 32'(k));
      chk("post_rst_take", 32'(if_take), 32'd0);
    end

`ifdef BPT_GSHARE_EN
    // Outcomes T,T,N at index 0 build history 0b110; pc index 6 then maps to 0.
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd0, 1);
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd0, 1);
    @(negedge clk); idle(); resolve(1, B_EQ, 0, 6'd0, 1);
    @(negedge clk); idle(); if_branch = 1; if_pc = 32'h18; #2;
    chk("gs_idx", 32'(if_idx), 32'd0);
    chk("gs_take", 32'(if_take), 32'd1);
    check_model();
    #1 rst_n = 0; #1;
    chk("gs_rst_idx", 32'(if_idx), 32'd6);
    chk("gs_rst_take", 32'(if_take), 32'd0);
    @(negedge clk); rst_n = 1;
`else
    // Post-reset training starts from weakly not-taken.
    @(negedge clk); idle(); resolve(1, B_EQ, 1, 6'd9, 1);
    @(negedge clk); idle(); if_branch = 1; if_pc = 32'h24; #2;
    chk("post_rst_train", 32'(if_take), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
